register_file: RTL and testbench
================================

// Module: register_file
// PURPOSE
//  Single-port addressable register file (DEPTH x WIDTH) with a synchronous write and a registered read.
//  - Read data is qualified by a one-cycle valid strobe.
//  - Serves as a generic scratch/config storage block; the class-based memory environment drives it through the shared interface.
// PARAMETERS
//  WIDTH    32  data word width in bits
//  DEPTH    16  number of words; must satisfy DEPTH <= 2**ADDRESS
//  ADDRESS  4   address bus width in bits
// PORTS
//  clk        in   1        rising-edge clock
//  rst        in   1        asynchronous active-low reset
//  in_data    in   WIDTH    write data
//  address    in   ADDRESS  shared read/write word address
//  wr_en      in   1        write enable, active high
//  rd_en      in   1        read enable, active high
//  out_data   out  WIDTH    registered read data
//  valid_out  out  1        high for exactly the cycle in which out_data holds a fresh read result
// BEHAVIOUR
//  - Reset (rst=0, asynchronous, independent of clk):
//    - all DEPTH words cleared to 0
//    - out_data=0, valid_out=0
//    - state held while rst=0; normal operation resumes on the first rising edge after rst deasserts
//    - reset mid-operation aborts any pending read; valid_out drops immediately
//  - Write: at posedge clk with wr_en=1, mem[address] <= in_data. Updated contents are visible to reads from the next edge.
//  - Read latency is 1 cycle:
//    - posedge with rd_en=1: out_data <= mem[address], valid_out <= 1
//    - posedge with rd_en=0: valid_out <= 0; out_data holds its last value
//  - Back-to-back reads: one result per cycle, valid_out stays high continuously.
//  - Simultaneous wr_en=1 and rd_en=1:
//    - both operations are performed
//    - the read returns the pre-write (old) contents, read-before-write
//    - exception: when the bypass feature under CONFIGURATION is compiled in
//  - Out-of-range address (address >= DEPTH):
//    - writes are ignored
//    - reads return 0 with valid_out=1
//  - No handshake back-pressure; wr_en and rd_en are sampled every cycle.
// CONFIGURATION
//  REG_FILE_BYPASS_EN
//    - Defined: when wr_en and rd_en are both 1 at the same in-range address, out_data <= in_data (write-through forwarding).
//    - Undefined: the read returns the old contents, read-before-write.
//    - All other behaviour is identical in both builds.
// STRUCTURE
//  - Package reg_file_pkg holds:
//    - localparams WIDTH_DEF=32, DEPTH_DEF=16, ADDRESS_DEF=4
//    - typedef logic [WIDTH_DEF-1:0] word_t
//    - typedef logic [ADDRESS_DEF-1:0] addr_t
//    - the transaction/opcode enum {OP_IDLE, OP_WRITE, OP_READ, OP_WR_RD} used by the verification environment
//  - One sub-module, reg_file_array:
//    - storage array with async clear and the write port
//    - combinational read port
//  - The top level adds the read output register, the valid strobe, range checking and the bypass mux.
// TESTING
//  1. Reset check: assert rst=0 mid-run with prior writes -> out_data=0, valid_out=0 immediately; a read of every address after release returns 0.
//  2. Write then read: write 0xDEADBEEF to addr 3, then rd_en at addr 3 next cycle -> one cycle later out_data=0xDEADBEEF, valid_out=1 for one cycle.
//  3. Full sweep: write addr i with 0xA5A50000+i for i=0..15, read back 0..15 back-to-back -> each value returned in order, valid_out continuously high for 16 cycles.
//  4. Same-cycle write+read at addr 5 (old 0x11, new 0x22) -> out_data=0x11 without REG_FILE_BYPASS_EN, 0x22 with it.
//  5. Idle hold: after reading 0x1234 do rd_en=0 for 3 cycles -> valid_out=0, out_data stays 0x1234.
//  6. wr_en=0, rd_en=0 with toggling in_data -> memory unchanged, confirmed by a subsequent read sweep.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared types and default sizes for the register file and its verification environment.
package reg_file_pkg;

    localparam int unsigned WIDTH_DEF   = 32;
    localparam int unsigned DEPTH_DEF   = 16;
    localparam int unsigned ADDRESS_DEF = 4;

    typedef logic [WIDTH_DEF-1:0]   word_t;
    typedef logic [ADDRESS_DEF-1:0] addr_t;

    // Transaction kinds issued by the memory environment
    typedef enum logic [1:0] {
        OP_IDLE  = 2'd0,
        OP_WRITE = 2'd1,
        OP_READ  = 2'd2,
        OP_WR_RD = 2'd3
    } op_e;

endpackage

// File: rtl/reg_file_array.sv
// Storage array: async clear, synchronous write port, combinational read port.
// Out-of-range addresses neither write nor return stored data (read yields 0).
module reg_file_array
    import reg_file_pkg::*;
#(
    parameter int unsigned WIDTH   = WIDTH_DEF,
    parameter int unsigned DEPTH   = DEPTH_DEF,
    parameter int unsigned ADDRESS = ADDRESS_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic [ADDRESS-1:0] address,
    input  logic [WIDTH-1:0]   wr_data,
    output logic [WIDTH-1:0]   rd_data
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic             in_range;
    logic [IDX_W-1:0] idx;

    assign in_range = ({1'b0, address} < (ADDRESS+1)'(DEPTH));
    assign idx      = IDX_W'(address);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem <= '{default: '0};
        end else if (wr_en && in_range) begin
            mem[idx] <= wr_data;
        end
    end

    always_comb begin
        rd_data = '0;
        if (in_range) begin
            rd_data = mem[idx];
        end
    end

endmodule

// File: rtl/register_file.sv
// Single-port DEPTH x WIDTH register file with synchronous write and 1-cycle registered read.
// Define REG_FILE_BYPASS_EN to forward in_data on a same-cycle in-range write+read.
module register_file
    import reg_file_pkg::*;
#(
    parameter int unsigned WIDTH   = WIDTH_DEF,
    parameter int unsigned DEPTH   = DEPTH_DEF,
    parameter int unsigned ADDRESS = ADDRESS_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [ADDRESS-1:0] address,
    input  logic               wr_en,
    input  logic               rd_en,
    output logic [WIDTH-1:0]   out_data,
    output logic               valid_out
);

    logic [WIDTH-1:0] rd_data;
    logic [WIDTH-1:0] rd_next;
    logic             in_range;

    assign in_range = ({1'b0, address} < (ADDRESS+1)'(DEPTH));

    reg_file_array #(
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .ADDRESS (ADDRESS)
    ) u_array (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .address (address),
        .wr_data (in_data),
        .rd_data (rd_data)
    );

    // Read source: stored (pre-write) word, or the incoming word when forwarding is built in
    always_comb begin
        rd_next = rd_data;
`ifdef REG_FILE_BYPASS_EN
        if (wr_en && in_range) begin
            rd_next = in_data;
        end
`else
        if (1'b0 && in_range) begin
            rd_next = in_data;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_data  <= '0;
            valid_out <= 1'b0;
        end else begin
            valid_out <= rd_en;
            if (rd_en) begin
                out_data <= rd_next;
            end
        end
    end

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file; honours REG_FILE_BYPASS_EN when defined.
`timescale 1ns/1ps
module tb_register_file;

    localparam int WIDTH   = 32;
    localparam int DEPTH   = 16;
    localparam int ADDRESS = 4;
`ifdef REG_FILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [WIDTH-1:0]   in_data = '0;
    logic [ADDRESS-1:0] address = '0;
    logic               wr_en = 1'b0;
    logic               rd_en = 1'b0;
    logic [WIDTH-1:0]   out_data;
    logic               valid_out;

    int total = 0;
    int bad   = 0;

    logic [WIDTH-1:0] model [DEPTH];
    logic [WIDTH-1:0] exp_out;
    logic             exp_valid;

    register_file #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDRESS(ADDRESS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .address   (address),
        .wr_en     (wr_en),
        .rd_en     (rd_en),
        .out_data  (out_data),
        .valid_out (valid_out)
    );

    always #5 clk = ~clk;

    // Reference: a read returns the word as it stood before this cycle's write,
    // unless forwarding is built in and a write hits the same in-range word.
    task automatic step(input bit w, input bit r, input logic [ADDRESS-1:0] a, input logic [WIDTH-1:0] d);
        bit hit;
        wr_en = w; rd_en = r; address = a; in_data = d;
        hit = (int'(a) < DEPTH);
        if (r) begin
            if (BYPASS && w && hit) exp_out = d;
            else                    exp_out = hit ? model[a] : '0;
        end
        exp_valid = r;
        if (w && hit) model[a] = d;
        @(posedge clk); #1;
    endtask

    task automatic clear_model();
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        exp_out = '0;
        exp_valid = 1'b0;
    endtask

    task automatic test_reset();
        clear_model();
        #2 rst = 1'b0;
        #1;
        total++;
        if (out_data !== '0 || valid_out !== 1'b0) begin
            bad++;
            $display("FAIL reset_initial: out_data=%h valid_out=%b required 0/0", out_data, valid_out);
        end
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, ADDRESS'(i), WIDTH'($urandom) | 32'h1);
        // Read in flight, then reset lands between edges
        step(1'b0, 1'b1, 4'd2, '0);
        wr_en = 1'b0; rd_en = 1'b1; address = 4'd4;
        #2 rst = 1'b0;
        #1;
        clear_model();
        total++;
        if (out_data !== '0 || valid_out !== 1'b0) begin
            bad++;
            $display("FAIL reset_midrun: out_data=%h valid_out=%b required 0/0", out_data, valid_out);
        end
        rd_en = 1'b0;
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 1'b1, ADDRESS'(i), '0);
            total++;
            if (out_data !== 32'h0 || valid_out !== 1'b1) begin
                bad++;
                $display("FAIL reset_clear addr=%0d: out_data=%h valid_out=%b required 0/1", i, out_data, valid_out);
            end
        end
        step(1'b0, 1'b0, '0, '0);
    endtask

    task automatic test_write_read();
        step(1'b1, 1'b0, 4'd3, 32'hDEADBEEF);
        total++;
        if (valid_out !== 1'b0) begin
            bad++;
            $display("FAIL wr_no_valid: valid_out=%b required 0", valid_out);
        end
        step(1'b0, 1'b1, 4'd3, '0);
        total++;
        if (out_data !== 32'hDEADBEEF || valid_out !== 1'b1) begin
            bad++;
            $display("FAIL write_read: out_data=%h valid_out=%b required deadbeef/1", out_data, valid_out);
        end
        step(1'b0, 1'b0, 4'd3, '0);
        total++;
        if (valid_out !== 1'b0 || out_data !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL valid_one_cycle: out_data=%h valid_out=%b required deadbeef/0", out_data, valid_out);
        end
    endtask

    task automatic test_sweep();
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, ADDRESS'(i), 32'hA5A50000 + WIDTH'(i));
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 1'b1, ADDRESS'(i), '0);
            total++;
            if (out_data !== 32'hA5A50000 + WIDTH'(i) || valid_out !== 1'b1) begin
                bad++;
                $display("FAIL sweep addr=%0d: out_data=%h valid_out=%b required %h/1",
                         i, out_data, valid_out, 32'hA5A50000 + WIDTH'(i));
            end
        end
        step(1'b0, 1'b0, '0, '0);
    endtask

    task automatic test_wr_rd_same();
        logic [WIDTH-1:0] want;
        want = BYPASS ? 32'h22 : 32'h11;
        step(1'b1, 1'b0, 4'd5, 32'h11);
        step(1'b1, 1'b1, 4'd5, 32'h22);
        total++;
        if (out_data !== want || valid_out !== 1'b1) begin
            bad++;
            $display("FAIL wr_rd_same: out_data=%h valid_out=%b required %h/1", out_data, valid_out, want);
        end
        step(1'b0, 1'b1, 4'd5, '0);
        total++;
        if (out_data !== 32'h22) begin
            bad++;
            $display("FAIL wr_rd_after: out_data=%h required 00000022", out_data);
        end
    endtask

    task automatic test_idle_hold();
        step(1'b1, 1'b0, 4'd7, 32'h1234);
        step(1'b0, 1'b1, 4'd7, '0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, ADDRESS'($urandom), WIDTH'($urandom));
            total++;
            if (valid_out !== 1'b0 || out_data !== 32'h1234) begin
                bad++;
                $display("FAIL idle_hold cyc=%0d: out_data=%h valid_out=%b required 00001234/0", i, out_data, valid_out);
            end
        end
    endtask

    task automatic test_no_op();
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, ADDRESS'(i), WIDTH'($urandom));
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 1'b1, ADDRESS'(i), WIDTH'($urandom));
            total++;
            if (out_data !== exp_out || valid_out !== 1'b1) begin
                bad++;
                $display("FAIL no_op_sweep addr=%0d: out_data=%h valid_out=%b required %h/1", i, out_data, valid_out, exp_out);
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            step(1'($urandom), 1'($urandom), ADDRESS'($urandom), WIDTH'($urandom));
            total++;
            if (out_data !== exp_out || valid_out !== exp_valid) begin
                bad++;
                $display("FAIL random n=%0d: out_data=%h valid_out=%b required %h/%b", n, out_data, valid_out, exp_out, exp_valid);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_sweep();
        test_wr_rd_same();
        test_idle_hold();
        test_no_op();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
